dut_step_sequencer: RTL and testbench

- Host-side initiator for the DUT wrapper's control/status register interface.
- Accepts single commands (RESET, STEP N host clocks, DUMP register file) and generates the control word for slv_reg0 and the RF address word for slv_reg1.
- Samples the PC (slv_reg5) and RF data (slv_reg6) words and streams register-file dumps out on a valid/ready port.
- Removes per-edge software toggling of clk_host.

---
 rtl/dut_host_pkg.sv | 36 +++
 rtl/seq_phase_timer.sv | 30 +++
 rtl/dut_step_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dut_step_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_host_pkg.sv
// Shared definitions for the DUT host-side step sequencer: command opcodes,
// control-word bit positions, FSM state encoding and register-file geometry.
package dut_host_pkg;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_RESET = 2'd1,
        OP_STEP  = 2'd2,
        OP_DUMP  = 2'd3
    } op_e;

    // Bit positions inside the slv_reg0 control word
    localparam int CTRL_RST = 0;
    localparam int CTRL_CLK = 1;
    localparam int CTRL_SEL = 2;

    // Register file seen through slv_reg1 / slv_reg6
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    // Phase timer width: every wait parameter fits in 1..255
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        STEP_HI,
        STEP_LO,
        DUMP_SET,
        DUMP_WAIT,
        DUMP_OUT,
        FINISH
    } state_e;

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Loading N makes tc rise on the N-th cycle after the load edge, so a state
// entered together with the load lasts exactly N cycles when it leaves on tc.
module seq_phase_timer
    import dut_host_pkg::*;
(
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               tc
);

    logic [TIMER_W-1:0] cnt;

    // Count down from the loaded value and park at zero
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign tc = (cnt == TIMER_W'(1));

endmodule

// File: rtl/dut_step_sequencer.sv
// Host-side initiator for the DUT wrapper register interface. Turns single
// RESET / STEP / DUMP commands into slv_reg0 control words and slv_reg1 RF
// addresses, captures the PC after stepping and streams RF dumps out on a
// valid/ready port. All outputs are registered from the next FSM state.
module dut_step_sequencer
    import dut_host_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int HALF_PERIOD        = 4,
    parameter int RST_CYCLES         = 8,
    parameter int SETTLE             = 2
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [15:0]                   cmd_count,
    input  logic                          sel_host,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_word,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rf_addr_word,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] pc_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] rf_data_in,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [RF_AW-1:0]              dump_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] dump_data,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pc_last,
    output logic [15:0]                   steps_done,
    output logic                          busy,
    output logic                          done
);

    localparam logic [TIMER_W-1:0] HALF_LD   = TIMER_W'(HALF_PERIOD);
    localparam logic [TIMER_W-1:0] RST_LD    = TIMER_W'(RST_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE);

    state_e                        state, next_state;
    op_e                           op;
    logic                          accept, beat_taken, last_step;
    logic                          timer_load, timer_tc;
    logic [TIMER_W-1:0]            timer_val;
    logic [15:0]                   step_target;
    logic [RF_AW-1:0]              idx, idx_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_d;

    assign op         = op_e'(cmd_op);
    assign accept     = cmd_valid & cmd_ready;
    assign beat_taken = dump_valid & dump_ready;
    assign last_step  = (steps_done == step_target);
    // A dump starts at index 0; every later DUMP_SET follows an accepted beat
    assign idx_next   = (state == DUMP_OUT) ? idx + RF_AW'(1) : '0;

    seq_phase_timer u_timer (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode
    // NOTE: defaulting next_state before the case keeps this block purely combinational (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_NOP:   next_state = FINISH;
                        OP_RESET: next_state = RST_HOLD;
                        OP_STEP:  next_state = (cmd_count == 16'd0) ? FINISH : STEP_HI;
                        OP_DUMP:  next_state = DUMP_SET;
                    endcase
                end
            end
            RST_HOLD:  if (timer_tc) next_state = FINISH;
            STEP_HI:   if (timer_tc) next_state = STEP_LO;
            STEP_LO:   if (timer_tc) next_state = last_step ? FINISH : STEP_HI;
            DUMP_SET:  next_state = DUMP_WAIT;
            DUMP_WAIT: if (timer_tc) next_state = DUMP_OUT;
            DUMP_OUT: begin
                if (beat_taken) begin
                    next_state = (idx == RF_AW'(RF_DEPTH - 1)) ? FINISH : DUMP_SET;
                end
            end
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output decode from the next state, plus phase-timer loading on state entry
    always_comb begin
        ctrl_d           = '0;
        ctrl_d[CTRL_RST] = (next_state == RST_HOLD);
        ctrl_d[CTRL_CLK] = (next_state == STEP_HI);
        ctrl_d[CTRL_SEL] = sel_host;

        timer_load = (next_state != state) &&
                     (next_state inside {RST_HOLD, STEP_HI, STEP_LO, DUMP_WAIT});
        case (next_state)
            RST_HOLD:         timer_val = RST_LD;
            STEP_HI, STEP_LO: timer_val = HALF_LD;
            DUMP_WAIT:        timer_val = SETTLE_LD;
            default:          timer_val = '0;
        endcase
    end

    // Registered handshake and control outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_word  <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            ctrl_word  <= ctrl_d;
            cmd_ready  <= (next_state == IDLE);
            busy       <= (next_state != IDLE);
            done       <= (next_state == FINISH);
            dump_valid <= (next_state == DUMP_OUT);
        end
    end

    // Step bookkeeping, PC capture and dump datapath
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            step_target  <= '0;
            steps_done   <= '0;
            pc_last      <= '0;
            idx          <= '0;
            rf_addr_word <= '0;
            dump_addr    <= '0;
            dump_data    <= '0;
        end else begin
            if (accept && op == OP_STEP) begin
                step_target <= cmd_count;
                steps_done  <= '0;
                if (cmd_count == 16'd0) pc_last <= pc_in;
            end
            // Count a host clock as issued when its high phase ends
            if (state == STEP_HI && next_state == STEP_LO) begin
                steps_done <= steps_done + 16'd1;
            end
            if (state == STEP_LO && next_state == FINISH) begin
                pc_last <= pc_in;
            end
            // The address is only rewritten when a new index is set, so it keeps 31 afterwards
            if (next_state == DUMP_SET) begin
                idx          <= idx_next;
                rf_addr_word <= C_S_AXI_DATA_WIDTH'(idx_next);
            end
            // The beat is loaded once on entry and then held until it is taken
            if (state == DUMP_WAIT && next_state == DUMP_OUT) begin
                dump_data <= rf_data_in;
                dump_addr <= idx;
            end
        end
    end

endmodule

// File: tb/tb_dut_step_sequencer.sv
// Scoreboard bench for dut_step_sequencer: the stimulus thread pushes the
// expected done/beat responses, a negedge monitor pops and compares them.
module tb_dut_step_sequencer;
    import dut_host_pkg::*;

    localparam int W  = 32;
    localparam int HP = 4;
    localparam int RC = 8;
    localparam int ST = 2;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [15:0]   cmd_count = 16'd0;
    logic          sel_host = 1'b0;
    logic [W-1:0]  ctrl_word, rf_addr_word, pc_in, rf_data_in;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [4:0]    dump_addr;
    logic [W-1:0]  dump_data, pc_last;
    logic [15:0]   steps_done;
    logic          busy, done;

    dut_step_sequencer #(
        .C_S_AXI_DATA_WIDTH (W),
        .HALF_PERIOD        (HP),
        .RST_CYCLES         (RC),
        .SETTLE             (ST)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .sel_host     (sel_host),
        .ctrl_word    (ctrl_word),
        .rf_addr_word (rf_addr_word),
        .pc_in        (pc_in),
        .rf_data_in   (rf_data_in),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .pc_last      (pc_last),
        .steps_done   (steps_done),
        .busy         (busy),
        .done         (done)
    );

    always #5 sysclk = ~sysclk;

    typedef struct { logic [4:0] addr; logic [31:0] data; } beat_t;
    typedef struct { logic [15:0] steps; logic [31:0] pc; } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];

    int checks = 0, failures = 0;
    int beats_seen = 0, pulses = 0, bad_hi = 0, rst_hi = 0, hi_run = 0;

    // PC model is a free-running cycle count; RF model only shows an
    // address's data two clocks after rf_addr_word changes
    logic [31:0] cyc = 32'd0;
    logic [4:0]  d1 = 5'd0, d2 = 5'd0;
    always @(posedge sysclk) begin
        cyc <= cyc + 32'd1;
        d1  <= rf_addr_word[4:0];
        d2  <= d1;
    end
    assign pc_in      = cyc;
    assign rf_data_in = 32'hA000_0000 + {27'b0, d2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: host clock/reset shape counters and scoreboard pops
    initial begin
        beat_t b;
        done_t d;
        forever begin
            @(negedge sysclk);
            if (ctrl_word[CTRL_RST]) rst_hi++;
            if (ctrl_word[CTRL_RST] && ctrl_word[CTRL_CLK]) bad_hi++;
            if (ctrl_word[CTRL_CLK]) begin
                hi_run++;
            end else if (hi_run > 0) begin
                pulses++;
                if (hi_run != HP) bad_hi++;
                hi_run = 0;
            end
            if (dump_valid && dump_ready) begin
                beats_seen++;
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", 64'(dump_addr), 64'hFFFF);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_addr", 64'(dump_addr), 64'(b.addr));
                    check("beat_data", 64'(dump_data), 64'(b.data));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 64'(1), 64'(0));
                end else begin
                    d = exp_done.pop_front();
                    check("done_steps", 64'(steps_done), 64'(d.steps));
                    check("done_pc", 64'(pc_last), 64'(d.pc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) return;
            tick();
        end
        check("ready_timeout", 64'(0), 64'(1));
    endtask

    // Drives one command for one edge; cmd_ready is already high here
    task automatic send(input op_e op, input logic [15:0] cnt);
        cmd_op    = op;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns the number of edges after acceptance until done is high
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (!done) begin
            if (lat >= budget) begin
                check("done_timeout", 64'(lat), 64'(budget + 1));
                lat = -1;
                return;
            end
            tick();
            lat++;
        end
    endtask

    logic [15:0] m_steps = 16'd0;
    logic [31:0] m_pc    = 32'd0;

    task automatic push_done();
        done_t d;
        d.steps = m_steps;
        d.pc    = m_pc;
        exp_done.push_back(d);
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < RF_DEPTH; i++) begin
            b.addr = 5'(i);
            b.data = 32'hA000_0000 + 32'(i);
            exp_beats.push_back(b);
        end
    endtask

    initial begin
        int lat, p0, b0, r0, h0, unstable;
        logic [4:0]  h_a;
        logic [31:0] h_d;

        // Reset values
        repeat (3) tick();
        check("rst_ctrl", 64'(ctrl_word), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(dump_valid), 64'(0));
        check("rst_steps", 64'(steps_done), 64'(0));
        check("rst_addr", 64'(rf_addr_word), 64'(0));
        rst_n = 1'b1;
        tick();
        check("post_ready", 64'(cmd_ready), 64'(1));
        check("post_busy", 64'(busy), 64'(0));
        check("post_ctrl", 64'(ctrl_word), 64'(0));
        sel_host = 1'b1;
        tick();
        check("sel_ctrl", 64'(ctrl_word), 64'h4);

        // NOP
        wait_ready();
        push_done();
        send(OP_NOP, 16'd7);
        wait_done(10, lat);
        check("nop_latency", 64'(lat), 64'(0));

        // RESET
        r0 = rst_hi; p0 = pulses; h0 = bad_hi;
        wait_ready();
        push_done();
        send(OP_RESET, 16'd0);
        check("rst_busy_on", 64'(busy), 64'(1));
        check("rst_word", 64'(ctrl_word), 64'h5);
        wait_done(50, lat);
        check("reset_latency", 64'(lat), 64'(RC));
        check("reset_hi_cycles", 64'(rst_hi - r0), 64'(RC));
        check("reset_no_clk", 64'(pulses - p0), 64'(0));
        check("reset_overlap", 64'(bad_hi - h0), 64'(0));

        // STEP 3
        p0 = pulses; h0 = bad_hi;
        wait_ready();
        m_steps = 16'd3;
        m_pc    = cyc + 32'(2 * HP * 3);
        push_done();
        send(OP_STEP, 16'd3);
        wait_done(100, lat);
        check("step3_latency", 64'(lat), 64'(2 * HP * 3));
        check("step3_pulses", 64'(pulses - p0), 64'(3));
        check("step3_width", 64'(bad_hi - h0), 64'(0));

        // STEP 0
        p0 = pulses;
        wait_ready();
        m_steps = 16'd0;
        m_pc    = cyc;
        push_done();
        send(OP_STEP, 16'd0);
        wait_done(2, lat);
        check("step0_latency", 64'(lat), 64'(0));
        check("step0_pulses", 64'(pulses - p0), 64'(0));

        // DUMP with ready held high
        dump_ready = 1'b1;
        b0 = beats_seen;
        wait_ready();
        push_dump();
        push_done();
        send(OP_DUMP, 16'd0);
        wait_done(400, lat);
        check("dump_latency", 64'(lat), 64'(RF_DEPTH * (2 + ST)));
        check("dump_beats", 64'(beats_seen - b0), 64'(RF_DEPTH));
        check("dump_left", 64'(exp_beats.size()), 64'(0));
        check("dump_last_addr", 64'(rf_addr_word), 64'(31));

        // DUMP with a 5-cycle stall on beat 7
        b0 = beats_seen;
        wait_ready();
        push_dump();
        push_done();
        send(OP_DUMP, 16'd0);
        for (int k = 0; k < 100 && (beats_seen - b0) < 7; k++) tick();
        check("stall_reach7", 64'(beats_seen - b0), 64'(7));
        dump_ready = 1'b0;
        for (int k = 0; k < 20 && !dump_valid; k++) tick();
        check("stall_valid", 64'(dump_valid), 64'(1));
        h_a = dump_addr;
        h_d = dump_data;
        unstable = 0;
        repeat (5) begin
            tick();
            if (!(dump_valid && dump_addr == h_a && dump_data == h_d)) unstable++;
        end
        check("stall_stable", 64'(unstable), 64'(0));
        check("stall_addr", 64'(h_a), 64'(7));
        check("stall_data", 64'(h_d), 64'h A000_0007);
        dump_ready = 1'b1;
        wait_done(400, lat);
        check("stall_beats", 64'(beats_seen - b0), 64'(RF_DEPTH));
        check("stall_left", 64'(exp_beats.size()), 64'(0));

        // Reset in the middle of STEP 100
        wait_ready();
        push_done();
        send(OP_STEP, 16'd100);
        for (int k = 0; k < 1000 && steps_done != 16'd40; k++) tick();
        check("mid_steps40", 64'(steps_done), 64'(40));
        rst_n = 1'b0;
        #1;
        check("mid_ctrl", 64'(ctrl_word), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_ready", 64'(cmd_ready), 64'(0));
        check("mid_steps", 64'(steps_done), 64'(0));
        exp_done.delete();
        m_steps = 16'd0;
        m_pc    = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        p0 = pulses; h0 = bad_hi;
        wait_ready();
        m_steps = 16'd2;
        m_pc    = cyc + 32'(2 * HP * 2);
        push_done();
        send(OP_STEP, 16'd2);
        wait_done(100, lat);
        check("step2_latency", 64'(lat), 64'(2 * HP * 2));
        check("step2_pulses", 64'(pulses - p0), 64'(2));
        check("step2_width", 64'(bad_hi - h0), 64'(0));

        repeat (3) tick();
        check("done_left", 64'(exp_done.size()), 64'(0));
        check("beats_left", 64'(exp_beats.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
